// File: rtl/gf180mcu_fd_io_asig_pkg.sv
// Shared types and defaults for the analog-switch break-before-make sequencer.
package gf180mcu_fd_io_asig_pkg;

    // Sequencer states: idle, all-off dwell, single-switch settle, completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_DONE  = 2'd3
    } asig_state_e;

    localparam int DEF_BBM_CYC    = 4;
    localparam int DEF_SETTLE_CYC = 16;

    // Larger of two integers, used to size the dwell counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_io__asig_dwell_cnt.sv
// Down-counting dwell timer: loads a value, counts to zero and holds there.
module gf180mcu_fd_io__asig_dwell_cnt
    import gf180mcu_fd_io_asig_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rn,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority over counting; the count stops once it reaches zero.
    always_ff @(posedge i_clk) begin
        if (!i_rn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gf180mcu_fd_io__asig_sw_seq.sv
// Break-before-make sequencer driving the core-side analog switch bank.
// Every channel change passes through an all-off dwell before the new
// switch closes, then waits for the pad node to settle before ACK.
module gf180mcu_fd_io__asig_sw_seq
    import gf180mcu_fd_io_asig_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int BBM_CYC    = DEF_BBM_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic           REQ,
    input  logic [2:0]     SEL,
    input  logic           OFF,
    output logic [NCH-1:0] SW_EN,
    output logic           ACK,
    output logic           ERR,
    output logic           BUSY,
    output logic           CONN,
    output logic [2:0]     CUR_CH
);

    localparam int CNT_MAX = max_int(BBM_CYC, SETTLE_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The counter is loaded with N-1 on entry so the state lasts exactly N cycles.
    localparam logic [CW-1:0] BBM_LOAD    = CW'(BBM_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

    asig_state_e    r_state;
    asig_state_e    w_state_next;

    logic [NCH-1:0] r_sw_en;
    logic [NCH-1:0] w_sw_en_next;
    logic           r_ack;
    logic           w_ack_next;
    logic           r_err;
    logic           w_err_next;
    logic           r_conn;
    logic           w_conn_next;
    logic [2:0]     r_cur_ch;
    logic [2:0]     w_cur_ch_next;
    logic [2:0]     r_sel_lat;
    logic [2:0]     w_sel_lat_next;
    logic           r_off_lat;
    logic           w_off_lat_next;

    logic           w_cnt_load;
    logic [CW-1:0]  w_cnt_value;
    logic           w_cnt_zero;
    logic           w_sel_in_range;
    logic [NCH-1:0] w_onehot;

    assign w_sel_in_range = (32'(SEL) < 32'(NCH));

    // Decode the latched channel into its switch enable.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_onehot
            assign w_onehot[gi] = (r_sel_lat == 3'(gi));
        end
    endgenerate

    gf180mcu_fd_io__asig_dwell_cnt #(
        .W (CW)
    ) u_dwell_cnt (
        .i_clk   (CLK),
        .i_rn    (RN),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .o_zero  (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus next values for the registered outputs.
    always_comb begin
        w_state_next   = r_state;
        w_sw_en_next   = r_sw_en;
        w_ack_next     = 1'b0;
        w_err_next     = 1'b0;
        w_conn_next    = r_conn;
        w_cur_ch_next  = r_cur_ch;
        w_sel_lat_next = r_sel_lat;
        w_off_lat_next = r_off_lat;
        w_cnt_load     = 1'b0;
        w_cnt_value    = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (REQ) begin
                    w_sel_lat_next = SEL;
                    w_off_lat_next = OFF;
                    w_cnt_load     = 1'b1;
                    if (!OFF && !w_sel_in_range) begin
                        // Rejected channel: report and leave the bank untouched.
                        w_state_next = ST_DONE;
                        w_ack_next   = 1'b1;
                        w_err_next   = 1'b1;
                    end else if (!OFF && r_conn && (SEL == r_cur_ch)) begin
                        // Already on the requested channel: nothing to switch.
                        w_state_next = ST_DONE;
                        w_ack_next   = 1'b1;
                    end else begin
                        w_state_next  = ST_BREAK;
                        w_cnt_value   = BBM_LOAD;
                        w_sw_en_next  = '0;
                        w_conn_next   = 1'b0;
                        w_cur_ch_next = 3'd0;
                    end
                end
            end
            ST_BREAK: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    if (r_off_lat) begin
                        w_state_next = ST_DONE;
                        w_ack_next   = 1'b1;
                    end else begin
                        w_state_next = ST_MAKE;
                        w_cnt_value  = SETTLE_LOAD;
                        w_sw_en_next = w_onehot;
                    end
                end
            end
            ST_MAKE: begin
                if (w_cnt_zero) begin
                    w_state_next  = ST_DONE;
                    w_cnt_load    = 1'b1;
                    w_ack_next    = 1'b1;
                    w_conn_next   = 1'b1;
                    w_cur_ch_next = r_sel_lat;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_load   = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output and request-latch registers; reset opens every switch at once.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_sw_en   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_conn    <= 1'b0;
            r_cur_ch  <= 3'd0;
            r_sel_lat <= 3'd0;
            r_off_lat <= 1'b0;
        end else begin
            r_sw_en   <= w_sw_en_next;
            r_ack     <= w_ack_next;
            r_err     <= w_err_next;
            r_conn    <= w_conn_next;
            r_cur_ch  <= w_cur_ch_next;
            r_sel_lat <= w_sel_lat_next;
            r_off_lat <= w_off_lat_next;
        end
    end

    assign SW_EN  = r_sw_en;
    assign ACK    = r_ack;
    assign ERR    = r_err;
    assign BUSY   = (r_state != ST_IDLE);
    assign CONN   = r_conn;
    assign CUR_CH = r_cur_ch;

endmodule

// File: tb/tb_gf180mcu_fd_io__asig_sw_seq.sv
// Scoreboard bench for the analog switch sequencer: stimulus pushes the
// expected completion, a negedge monitor pops and compares on each ACK.
module tb_gf180mcu_fd_io__asig_sw_seq;

    localparam int NCH    = 4;
    localparam int BBM    = 4;
    localparam int SETTLE = 16;

    logic           CLK = 1'b0;
    logic           RN  = 1'b0;
    logic           REQ = 1'b0;
    logic [2:0]     SEL = 3'd0;
    logic           OFF = 1'b0;
    logic [NCH-1:0] SW_EN;
    logic           ACK;
    logic           ERR;
    logic           BUSY;
    logic           CONN;
    logic [2:0]     CUR_CH;

    always #5 CLK = ~CLK;

    gf180mcu_fd_io__asig_sw_seq #(
        .NCH        (NCH),
        .BBM_CYC    (BBM),
        .SETTLE_CYC (SETTLE)
    ) u_dut (
        .CLK    (CLK),
        .RN     (RN),
        .REQ    (REQ),
        .SEL    (SEL),
        .OFF    (OFF),
        .SW_EN  (SW_EN),
        .ACK    (ACK),
        .ERR    (ERR),
        .BUSY   (BUSY),
        .CONN   (CONN),
        .CUR_CH (CUR_CH)
    );

    typedef struct {
        int         id;
        int         ack_edge;
        logic       err;
        logic [3:0] sw;
        logic       conn;
        logic [2:0] cur;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;
    logic [3:0] last_nz  = 4'b0000;
    int         zero_run = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: per-cycle switch safety checks plus scoreboard compare on ACK.
    always @(negedge CLK) begin
        if (mon_en) begin
            chk($countones(SW_EN) <= 1, "sw_onehot_bits", $countones(SW_EN), 1);
            chk(!(ERR && !ACK), "err_without_ack", int'(ERR), int'(ACK));
            if (SW_EN == 4'b0000) begin
                zero_run = zero_run + 1;
            end else begin
                if (last_nz != 4'b0000 && SW_EN != last_nz)
                    chk(zero_run >= BBM, "bbm_dwell", zero_run, BBM);
                last_nz  = SW_EN;
                zero_run = 0;
            end
            if (ACK) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_ack", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn %0d ack at edge %0d sw=%b conn=%0d cur=%0d err=%0d",
                             mon_e.id, edge_cnt, SW_EN, CONN, CUR_CH, ERR);
                    chk(edge_cnt == mon_e.ack_edge, "ack_cycle", edge_cnt, mon_e.ack_edge);
                    chk(ERR == mon_e.err, "ack_err", int'(ERR), int'(mon_e.err));
                    chk(SW_EN == mon_e.sw, "ack_sw_en", int'(SW_EN), int'(mon_e.sw));
                    chk(CONN == mon_e.conn, "ack_conn", int'(CONN), int'(mon_e.conn));
                    chk(CUR_CH == mon_e.cur, "ack_cur_ch", int'(CUR_CH), int'(mon_e.cur));
                end
            end
        end
    end

    // Issue one request; returns at the negedge of cycle k+1 with REQ dropped.
    task automatic issue(input int id, input logic [2:0] sel, input logic off, input int lat,
                         input bit push, input logic e_err, input logic [3:0] e_sw,
                         input logic e_conn, input logic [2:0] e_cur);
        exp_t e;
        @(negedge CLK);
        REQ = 1'b1;
        SEL = sel;
        OFF = off;
        if (push) begin
            e.id       = id;
            e.ack_edge = edge_cnt + 1 + lat;
            e.err      = e_err;
            e.sw       = e_sw;
            e.conn     = e_conn;
            e.cur      = e_cur;
            sb.push_back(e);
        end
        @(negedge CLK);
        REQ = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk(!BUSY, name, int'(BUSY), 0);
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e7;
        RN = 1'b0;
        repeat (3) @(negedge CLK);
        chk(SW_EN == 4'b0000, "rst_sw_en", int'(SW_EN), 0);
        chk(ACK == 1'b0, "rst_ack", int'(ACK), 0);
        chk(ERR == 1'b0, "rst_err", int'(ERR), 0);
        chk(BUSY == 1'b0, "rst_busy", int'(BUSY), 0);
        chk(CONN == 1'b0, "rst_conn", int'(CONN), 0);
        chk(CUR_CH == 3'd0, "rst_cur_ch", int'(CUR_CH), 0);
        RN     = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK);

        // T1: connect channel 2 from nothing.
        issue(1, 3'd2, 1'b0, BBM + SETTLE, 1'b1, 1'b0, 4'b0100, 1'b1, 3'd2);
        chk(SW_EN == 4'b0000, "t1_break_sw_first", int'(SW_EN), 0);
        chk(BUSY == 1'b1, "t1_busy", int'(BUSY), 1);
        chk(CONN == 1'b0, "t1_conn_break", int'(CONN), 0);
        repeat (3) @(negedge CLK);
        chk(SW_EN == 4'b0000, "t1_break_sw_last", int'(SW_EN), 0);
        @(negedge CLK);
        chk(SW_EN == 4'b0100, "t1_make_sw", int'(SW_EN), 4);
        wait_idle("t1_idle");

        // T2: switch 2 -> 1; a stray REQ/SEL/OFF during BREAK must be ignored.
        issue(2, 3'd1, 1'b0, BBM + SETTLE, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd1);
        chk(SW_EN == 4'b0000, "t2_break_sw", int'(SW_EN), 0);
        @(negedge CLK);
        REQ = 1'b1; SEL = 3'd3; OFF = 1'b1;
        @(negedge CLK);
        REQ = 1'b0; SEL = 3'd0; OFF = 1'b0;
        wait_idle("t2_idle");

        // T3: same channel again -> immediate ACK, no switching.
        issue(3, 3'd1, 1'b0, 0, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd1);
        chk(BUSY == 1'b1, "t3_busy_k1", int'(BUSY), 1);
        @(negedge CLK);
        chk(BUSY == 1'b0, "t3_busy_k2", int'(BUSY), 0);
        chk(SW_EN == 4'b0010, "t3_sw_held", int'(SW_EN), 2);
        wait_idle("t3_idle");

        // T4: out-of-range channel -> ACK+ERR, bank unchanged.
        issue(4, 3'd5, 1'b0, 0, 1'b1, 1'b1, 4'b0010, 1'b1, 3'd1);
        chk(SW_EN == 4'b0010, "t4_sw_held", int'(SW_EN), 2);
        wait_idle("t4_idle");

        // T5: disconnect all.
        issue(5, 3'd0, 1'b1, BBM, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
        chk(SW_EN == 4'b0000, "t5_sw_k1", int'(SW_EN), 0);
        chk(CONN == 1'b0, "t5_conn_k1", int'(CONN), 0);
        wait_idle("t5_idle");

        // T6: reset during MAKE cycle 3 aborts with no ACK.
        issue(6, 3'd3, 1'b0, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
        repeat (6) @(negedge CLK);
        chk(SW_EN == 4'b1000, "t6_make_sw", int'(SW_EN), 8);
        RN = 1'b0;
        @(negedge CLK);
        chk(SW_EN == 4'b0000, "t6_rst_sw", int'(SW_EN), 0);
        chk(BUSY == 1'b0, "t6_rst_busy", int'(BUSY), 0);
        chk(ACK == 1'b0, "t6_rst_ack", int'(ACK), 0);
        @(negedge CLK);
        REQ = 1'b1; SEL = 3'd0; OFF = 1'b0;

        // T7: REQ already high on the first cycle after reset release.
        @(negedge CLK);
        RN = 1'b1;
        e7.id       = 7;
        e7.ack_edge = edge_cnt + 1 + BBM + SETTLE;
        e7.err      = 1'b0;
        e7.sw       = 4'b0001;
        e7.conn     = 1'b1;
        e7.cur      = 3'd0;
        sb.push_back(e7);
        @(negedge CLK);
        REQ = 1'b0;
        chk(BUSY == 1'b1, "t7_accepted", int'(BUSY), 1);
        wait_idle("t7_idle");

        repeat (3) @(negedge CLK);
        chk(sb.size() == 0, "sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_io__asig_sw_seq.md
GF180MCU_FD_IO__ASIG_SW_SEQ -- requirements
Module: gf180mcu_fd_io__asig_sw_seq

Core-side break-before-make sequencer for the analog switch bank joining core analog channels to the 5V analog signal pad.

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of switchable core channels (legal range 2..8).
REQ-002 SHALL have parameter BBM_CYC, default 4, meaning the all-switches-off dwell in cycles (legal range >=1).
REQ-003 SHALL have parameter SETTLE_CYC, default 16, meaning the post-make settle time in cycles (legal range >=1).
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port RN  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port REQ  input  1  connect/disconnect request, level-sampled.
REQ-007 SHALL have port SEL  input  3  requested channel index.
REQ-008 SHALL have port OFF  input  1  when high with REQ, disconnect all channels.
REQ-009 SHALL have port SW_EN  output  NCH  one-hot-or-zero switch enables, registered.
REQ-010 SHALL have port ACK  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ERR  output  1  one-cycle pulse coincident with ACK; marks a rejected SEL.
REQ-012 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port CONN  output  1  high when a channel is connected and settled.
REQ-014 SHALL have port CUR_CH  output  3  index of the connected channel; 0 when CONN is low.

Function
REQ-015 SHALL implement FSM states IDLE, BREAK, MAKE and DONE.
REQ-016 SHALL sample REQ only in IDLE; REQ seen in any other state SHALL be ignored (no queuing).
REQ-017 In IDLE with REQ=1, OFF=0 and SEL>=NCH, the FSM SHALL go to DONE with ERR set and leave SW_EN, CONN and CUR_CH unchanged.
REQ-018 In IDLE with REQ=1, OFF=0, CONN=1 and SEL==CUR_CH, the FSM SHALL go directly to DONE (ACK one cycle after acceptance, no switching).
REQ-019 Any other accepted REQ SHALL enter BREAK, clear SW_EN to 0 and clear CONN from the first BREAK cycle.
REQ-020 BREAK SHALL last exactly BBM_CYC cycles; SW_EN SHALL be all-zero throughout.
REQ-021 After BREAK: if OFF was high at acceptance, the FSM SHALL go to DONE; otherwise it SHALL go to MAKE.
REQ-022 MAKE SHALL set SW_EN to onehot(SEL latched at acceptance) and hold it for exactly SETTLE_CYC cycles before DONE.
REQ-023 DONE SHALL last 1 cycle, assert ACK, update CONN/CUR_CH, then return to IDLE.
REQ-024 SEL and OFF SHALL be latched at acceptance; later changes SHALL have no effect on the request in progress.
REQ-025 SW_EN SHALL never have more than one bit set in any cycle, and SHALL never go from one nonzero value to another without at least BBM_CYC all-zero cycles between them.
REQ-026 Latency from REQ acceptance at edge k: ACK in cycle k+BBM_CYC+SETTLE_CYC+1 (connect), k+BBM_CYC+1 (disconnect), k+1 (same-channel or error).
REQ-027 The dwell counter SHALL be sized clog2(max(BBM_CYC,SETTLE_CYC)+1) bits, count down, and be reloaded on every state entry.

Reset
REQ-028 With RN low at a CLK edge: state=IDLE, SW_EN=0, ACK=0, ERR=0, BUSY=0, CONN=0, CUR_CH=0, counter=0.
REQ-029 Reset asserted mid-BREAK or mid-MAKE SHALL drop SW_EN to 0 at that edge with no ACK issued.
REQ-030 REQ held high during the first cycle after reset release SHALL be accepted normally.

Structure
REQ-031 Package gf180mcu_fd_io_asig_pkg SHALL hold the FSM state enum and the default BBM_CYC/SETTLE_CYC constants.
REQ-032 The dwell counter SHALL be a sub-module, gf180mcu_fd_io__asig_dwell_cnt (load, value, zero flag).

Verification
REQ-033 Reset, then REQ=1, SEL=2, OFF=0 at edge 0 -> SW_EN=0 for cycles 1-4, SW_EN=4'b0100 for cycles 5-20, ACK/CONN=1 and CUR_CH=2 at cycle 21.
REQ-034 While connected to channel 2, request SEL=1 -> SW_EN=0 for 4 cycles, then 4'b0010; no cycle shows two bits set.
REQ-035 While connected to channel 1, request SEL=1 -> ACK at k+1, SW_EN held at 4'b0010, BUSY high for 1 cycle.
REQ-036 Request SEL=5 with NCH=4 -> ACK=ERR=1 at k+1, SW_EN unchanged; then OFF=1 -> SW_EN=0 at k+1, ACK at k+5, CONN=0.
REQ-037 RN low in MAKE cycle 3 -> SW_EN=0 and BUSY=0 next cycle, no ACK; REQ and SEL changes during BUSY are ignored.
